qspi_tx_shifter: RTL and testbench
==================================

QSPI_TX_SHIFTER -- requirements
Module: qspi_tx_shifter

Interface
REQ-001 Parameter MAX_BYTES, default 4, maximum bytes per transfer; legal values 1..8.
REQ-002 Parameter CW, default $clog2(MAX_BYTES+1), width of nbytes_in.
REQ-003 clk  input  1  system clock (HCLK); all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  8*MAX_BYTES  payload (address/data); used bytes right-aligned, first byte sent is data_in[8*nbytes_in-1 -: 8].
REQ-006 nbytes_in  input  CW  bytes to send; sampled on accepted start.
REQ-007 lane_mode_in  input  2  00 single (IO0), 01 dual (IO1:IO0), 10 quad (IO3:IO0), 11 reserved = single; sampled on accepted start.
REQ-008 start  input  1  request to load and begin a transfer.
REQ-009 shift_en  input  1  one-cycle strobe from SCLK generator; advances one SCLK beat.
REQ-010 abort  input  1  cancel in-progress transfer.
REQ-011 io_out  output  4  data driven to pads, MSB-first.
REQ-012 io_oe  output  4  per-line output enable to pad tristate.
REQ-013 busy  output  1  high in SHIFT state.
REQ-014 done  output  1  one-cycle pulse when transfer completes normally.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE: start=1, abort=0, nbytes_in!=0 -> load, go SHIFT next cycle; nbytes_in=0 -> start ignored, stay IDLE.
REQ-017 nbytes_in > MAX_BYTES clamped to MAX_BYTES.
REQ-018 Load: shift register (8*MAX_BYTES bits) = data_in << 8*(MAX_BYTES-n), n = effective byte count, so first bit at register MSB.
REQ-019 Load: beat counter = 8n (single), 4n (dual), 2n (quad); lane mode latched internally, later lane_mode_in changes ignored.
REQ-020 SHIFT, shift_en=1: register shifts left by 1/2/4 bits (zero fill), counter decrements by 1.
REQ-021 SHIFT, shift_en=1 with counter=1: go DONE next cycle.
REQ-022 DONE: done=1 for exactly one cycle, unconditional return to IDLE.
REQ-023 io_out in SHIFT: single io_out[0]=reg MSB; dual io_out[1:0]=reg[MSB:MSB-1]; quad io_out[3:0]=reg[MSB:MSB-3]; undriven lanes 0.
REQ-024 io_oe in SHIFT: 0001 single, 0011 dual, 1111 quad; 0000 in IDLE and DONE.
REQ-025 io_out = 0000 whenever io_oe = 0000; no X/Z generated inside block.
REQ-026 start in SHIFT or DONE ignored, no reload.
REQ-027 shift_en in IDLE or DONE ignored.
REQ-028 abort=1 in SHIFT: IDLE next cycle, io_oe=0000, no done pulse, counter cleared; abort has priority over shift_en.
REQ-029 abort=1 with start=1 in IDLE: abort wins, stay IDLE.
REQ-030 abort in DONE: done pulse still issued (transfer already complete).
REQ-031 Output latency: io_out/io_oe valid cycle after start accepted; each shift_en updates io_out the following cycle.
REQ-032 busy = (state==SHIFT); done registered, not combinational.

Reset
REQ-033 rst_n low, any state: immediately IDLE, shift register 0, counter 0, lane mode single, io_out=0000, io_oe=0000, busy=0, done=0.
REQ-034 Reset mid-transfer discards data; no done pulse on or after reset release.
REQ-035 First start accepted on first rising clk after rst_n deasserts.

Verification
REQ-036 MAX_BYTES=4, n=3, single, data_in=0x00A5C33C -> io_oe=0001, 24 shift_en beats, io_out[0] serial 1010_0101_1100_0011_0011_1100, done after 24th.
REQ-037 n=4, quad, data_in=0x12345678 -> io_oe=1111, nibbles 1,2,3,4,5,6,7,8 over 8 beats, one done pulse, busy low after.
REQ-038 n=1, dual, data_in=0x000000B4 -> io_oe=0011, pairs 10,11,01,00 over 4 beats, then done.
REQ-039 Quad n=4 abort after 3 beats -> IDLE next cycle, io_oe=0000, no done; new start (n=2, single) runs 16 beats normally.
REQ-040 start with nbytes_in=0, and start during SHIFT -> ignored, state/counter unchanged; nbytes_in=7 clamps to 4 (32 single beats).
REQ-041 rst_n asserted at beat 10 of 24 -> all outputs reset values asynchronously, no done; gaps between shift_en strobes do not change io_out.

Source files
------------

// File: rtl/qspi_tx_shifter.sv
// QSPI transmit shifter: loads up to MAX_BYTES of payload and shifts it out MSB-first
// over 1, 2 or 4 IO lanes, one beat per shift_en strobe from the SCLK generator.
module qspi_tx_shifter #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*MAX_BYTES-1:0] data_in,
  input  logic [CW-1:0]          nbytes_in,
  input  logic [1:0]             lane_mode_in,
  input  logic                   start,
  input  logic                   shift_en,
  input  logic                   abort,
  output logic [3:0]             io_out,
  output logic [3:0]             io_oe,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned SW   = 8 * MAX_BYTES;
  localparam int unsigned CNTW = $clog2(SW + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DUAL   = 2'b01;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;

  int unsigned     n_eff;
  logic [1:0]      mode_eff;

  always_comb begin
    // Oversized byte counts are clamped; reserved lane mode falls back to single.
    n_eff    = (int'(nbytes_in) > int'(MAX_BYTES)) ? MAX_BYTES : int'(nbytes_in);
    mode_eff = (lane_mode_in == 2'b11) ? MODE_SINGLE : lane_mode_in;

    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort && (nbytes_in != '0)) begin
          state_d = ST_SHIFT;
          mode_d  = mode_eff;
          shreg_d = data_in << (8 * (MAX_BYTES - n_eff));
          case (mode_eff)
            MODE_DUAL: cnt_d = CNTW'(n_eff * 4);
            MODE_QUAD: cnt_d = CNTW'(n_eff * 2);
            default:   cnt_d = CNTW'(n_eff * 8);
          endcase
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (shift_en) begin
          case (mode_q)
            MODE_DUAL: shreg_d = shreg_q << 2;
            MODE_QUAD: shreg_d = shreg_q << 4;
            default:   shreg_d = shreg_q << 1;
          endcase
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_SINGLE;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Pads are driven straight from registered state so io_out/io_oe never glitch on inputs.
  always_comb begin
    io_out = 4'b0000;
    io_oe  = 4'b0000;
    if (state_q == ST_SHIFT) begin
      case (mode_q)
        MODE_DUAL: begin
          io_out = {2'b00, shreg_q[SW-1 -: 2]};
          io_oe  = 4'b0011;
        end
        MODE_QUAD: begin
          io_out = shreg_q[SW-1 -: 4];
          io_oe  = 4'b1111;
        end
        default: begin
          io_out = {3'b000, shreg_q[SW-1]};
          io_oe  = 4'b0001;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// Directed bench for qspi_tx_shifter: lane modes, clamping, abort, ignored strobes and
// asynchronous reset, with expected pad values derived from the payload constants.
module tb_qspi_tx_shifter;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [2:0]  nbytes_in;
  logic [1:0]  lane_mode_in;
  logic        start;
  logic        shift_en;
  logic        abort;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  qspi_tx_shifter #(
    .MAX_BYTES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .nbytes_in    (nbytes_in),
    .lane_mode_in (lane_mode_in),
    .start        (start),
    .shift_en     (shift_en),
    .abort        (abort),
    .io_out       (io_out),
    .io_oe        (io_oe),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs stop_after beats of a transfer; a full run also checks the done pulse.
  task automatic run_xfer(input string tag, input logic [31:0] data, input logic [2:0] n,
                          input logic [1:0] mode, input logic [31:0] exp_bits, input int w,
                          input int beats, input logic [3:0] oe, input int stop_after);
    logic [3:0] mask;
    logic [3:0] exp_o;
    int gap;
    mask = (w == 4) ? 4'hF : (w == 2) ? 4'h3 : 4'h1;
    data_in = data;
    nbytes_in = n;
    lane_mode_in = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in = 32'hFFFF_FFFF;
    lane_mode_in = (mode == 2'b10) ? 2'b00 : 2'b10;
    check($sformatf("%s busy", tag), busy, 1);
    for (int b = 0; b < stop_after; b++) begin
      exp_o = 4'(exp_bits >> (w * (beats - 1 - b))) & mask;
      check($sformatf("%s io_out b%0d", tag, b), io_out, exp_o);
      check($sformatf("%s io_oe b%0d", tag, b), io_oe, oe);
      check($sformatf("%s done b%0d", tag, b), done, 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start = 1'b1;
        nbytes_in = 3'd4;
        tick();
        start = 1'b0;
        check($sformatf("%s gap io_out b%0d", tag, b), io_out, exp_o);
        check($sformatf("%s gap busy b%0d", tag, b), busy, 1);
      end
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
    end
    if (stop_after == beats) begin
      check($sformatf("%s done", tag), done, 1);
      check($sformatf("%s busy at done", tag), busy, 0);
      check($sformatf("%s io_oe at done", tag), io_oe, 0);
      check($sformatf("%s io_out at done", tag), io_out, 0);
      abort = 1'b1;
      shift_en = 1'b1;
      check($sformatf("%s done with abort", tag), done, 1);
      tick();
      abort = 1'b0;
      shift_en = 1'b0;
      check($sformatf("%s done single cycle", tag), done, 0);
      check($sformatf("%s idle after", tag), busy, 0);
      tick();
      check($sformatf("%s no reload", tag), busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = '0;
    nbytes_in = '0;
    lane_mode_in = '0;
    start = 1'b0;
    shift_en = 1'b0;
    abort = 1'b0;
    #1;
    check("reset io_out", io_out, 0);
    check("reset io_oe", io_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // First start right after reset release; single lane, 3 bytes.
    run_xfer("single3", 32'h00A5_C33C, 3'd3, 2'b00, 32'h00A5_C33C, 1, 24, 4'b0001, 24);
    run_xfer("quad4", 32'h1234_5678, 3'd4, 2'b10, 32'h1234_5678, 4, 8, 4'b1111, 8);
    run_xfer("dual1", 32'h0000_00B4, 3'd1, 2'b01, 32'h0000_00B4, 2, 4, 4'b0011, 4);
    run_xfer("rsvd1", 32'hFFFF_FF5A, 3'd1, 2'b11, 32'h0000_005A, 1, 8, 4'b0001, 8);

    // Abort after three quad beats; abort outranks a simultaneous shift_en.
    run_xfer("abortq", 32'h1234_5678, 3'd4, 2'b10, 32'h1234_5678, 4, 8, 4'b1111, 3);
    abort = 1'b1;
    shift_en = 1'b1;
    tick();
    abort = 1'b0;
    shift_en = 1'b0;
    check("abort busy", busy, 0);
    check("abort io_oe", io_oe, 0);
    check("abort io_out", io_out, 0);
    check("abort done", done, 0);
    tick();
    check("abort no late done", done, 0);
    run_xfer("after_abort", 32'h1234_BEEF, 3'd2, 2'b00, 32'h0000_BEEF, 1, 16, 4'b0001, 16);

    // Zero-length start and abort-with-start are both ignored in IDLE.
    data_in = 32'h1234_5678;
    nbytes_in = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero len busy", busy, 0);
    check("zero len io_oe", io_oe, 0);
    nbytes_in = 3'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort+start busy", busy, 0);
    check("abort+start io_oe", io_oe, 0);

    run_xfer("clamp7", 32'hDEAD_BEEF, 3'd7, 2'b00, 32'hDEAD_BEEF, 1, 32, 4'b0001, 32);

    // Asynchronous reset in the middle of beat 10.
    run_xfer("rst_mid", 32'h00A5_C33C, 3'd3, 2'b00, 32'h00A5_C33C, 1, 24, 4'b0001, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst io_out", io_out, 0);
    check("async rst io_oe", io_oe, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1;
      tick();
      check($sformatf("post rst done c%0d", i), done, 0);
      check($sformatf("post rst busy c%0d", i), busy, 0);
    end
    shift_en = 1'b0;
    run_xfer("post_rst", 32'h0000_3C96, 3'd2, 2'b10, 32'h0000_3C96, 4, 4, 4'b1111, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
